line_counter_multi: RTL and testbench

Multi-channel successor to the single-line pulse counter. Counts rising edges on CHANNELS asynchronous line inputs in the CLK domain:
- each line passes through a synchroniser and an edge detector, then feeds a per-channel counter;
- counters are WIDTH bits, with selectable wrap or saturate mode;
- a capture strobe snapshots all counters at once, and the snapshots are read through a registered channel mux.

It sits between external line/sense inputs and the host register interface.

---
 rtl/line_counter_multi.sv | 113 +++++++++++
 tb/tb_line_counter_multi.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_counter_multi.sv
// Multi-channel rising-edge counter with capture snapshots and registered read-back mux.
// Optional Limit/Irq compare is built only when LINE_COUNTER_LIMIT_IRQ_EN is defined.
module line_counter_multi #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SATURATE    = 0,
  localparam int SELW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [CHANNELS-1:0] Lines,
  input  logic                Enable,
  input  logic [CHANNELS-1:0] Clear,
  input  logic                Capture,
  input  logic [SELW-1:0]     Sel,
`ifdef LINE_COUNTER_LIMIT_IRQ_EN
  input  logic [WIDTH-1:0]    Limit,
  output logic [CHANNELS-1:0] Irq,
`endif
  output logic [WIDTH-1:0]    Counted,
  output logic [CHANNELS-1:0] Overflow,
  output logic                CaptureDone
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_prev;
  logic [CHANNELS-1:0] edge_q;
  logic [SYNC_STAGES:0] prime_q;

  logic [WIDTH-1:0]    cnt_q  [CHANNELS];
  logic [WIDTH-1:0]    cnt_d  [CHANNELS];
  logic [WIDTH-1:0]    snap_q [CHANNELS];
  logic [CHANNELS-1:0] ovf_d;

  // prime_q fills with ones after reset; until the synchroniser and history hold real
  // line values, edges are masked so a line already high at release is not counted.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      sync_prev <= '0;
      edge_q    <= '0;
      prime_q   <= '0;
    end else begin
      sync_q[0] <= Lines;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      sync_prev <= sync_q[SYNC_STAGES-1];
      edge_q    <= sync_q[SYNC_STAGES-1] & ~sync_prev & {CHANNELS{&prime_q}};
      prime_q   <= {prime_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  always_comb begin
    ovf_d = Overflow;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (Clear[i]) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (Enable && edge_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = (SATURATE != 0) ? CNT_MAX : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
        end
      end
    end
  end

  // Snapshots sample the pre-update counters, so a same-cycle increment or clear is excluded.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      Overflow    <= '0;
      CaptureDone <= 1'b0;
      Counted     <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (Capture) snap_q[i] <= cnt_q[i];
      end
      Overflow    <= ovf_d;
      CaptureDone <= Capture;
      Counted     <= (int'(Sel) < CHANNELS) ? snap_q[Sel] : '0;
    end
  end

`ifdef LINE_COUNTER_LIMIT_IRQ_EN
  logic [CHANNELS-1:0] irq_d;

  // Fires only on a real increment landing on Limit; a held or wrapped count never matches.
  always_comb begin
    irq_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!Clear[i] && Enable && edge_q[i] && (cnt_q[i] != CNT_MAX) &&
          (Limit != '0) && ((cnt_q[i] + WIDTH'(1)) == Limit))
        irq_d[i] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) Irq <= '0;
    else        Irq <= irq_d;
  end
`endif

endmodule

// File: tb/tb_line_counter_multi.sv
// Bench for line_counter_multi: three configurations (4ch/16b wrap, 3ch/4b wrap,
// 3ch/4b saturate) driven from shared stimulus.
module tb_line_counter_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  lines;
  logic        enable;
  logic [3:0]  clear;
  logic        capture;
  logic [1:0]  sel;

  logic [15:0] counted_a;
  logic [3:0]  counted_w, counted_s;
  logic [3:0]  ovf_a;
  logic [2:0]  ovf_w, ovf_s;
  logic        done_a, done_w, done_s;
`ifdef LINE_COUNTER_LIMIT_IRQ_EN
  logic [15:0] limit_a;
  logic [3:0]  limit_small;
  logic [3:0]  irq_a;
  logic [2:0]  irq_w, irq_s;
`endif

  line_counter_multi #(.CHANNELS(4), .WIDTH(16), .SYNC_STAGES(2), .SATURATE(0)) dut_a (
    .CLK(clk), .Reset(rst_n), .Lines(lines), .Enable(enable), .Clear(clear),
    .Capture(capture), .Sel(sel),
`ifdef LINE_COUNTER_LIMIT_IRQ_EN
    .Limit(limit_a), .Irq(irq_a),
`endif
    .Counted(counted_a), .Overflow(ovf_a), .CaptureDone(done_a));

  line_counter_multi #(.CHANNELS(3), .WIDTH(4), .SYNC_STAGES(2), .SATURATE(0)) dut_w (
    .CLK(clk), .Reset(rst_n), .Lines(lines[2:0]), .Enable(enable), .Clear(clear[2:0]),
    .Capture(capture), .Sel(sel),
`ifdef LINE_COUNTER_LIMIT_IRQ_EN
    .Limit(limit_small), .Irq(irq_w),
`endif
    .Counted(counted_w), .Overflow(ovf_w), .CaptureDone(done_w));

  line_counter_multi #(.CHANNELS(3), .WIDTH(4), .SYNC_STAGES(2), .SATURATE(1)) dut_s (
    .CLK(clk), .Reset(rst_n), .Lines(lines[2:0]), .Enable(enable), .Clear(clear[2:0]),
    .Capture(capture), .Sel(sel),
`ifdef LINE_COUNTER_LIMIT_IRQ_EN
    .Limit(limit_small), .Irq(irq_s),
`endif
    .Counted(counted_s), .Overflow(ovf_s), .CaptureDone(done_s));

  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0]  mask;
    int          n;
    logic        en;
    logic [3:0]  clr;
    logic [1:0]  sel;
    logic [15:0] exp_a;
    logic [3:0]  exp_w;
    logic [3:0]  exp_s;
    logic [3:0]  eovf_a;
    logic [2:0]  eovf_w;
    logic [2:0]  eovf_s;
  } vec_t;

  vec_t vecs[12];

  // Reference model: per configuration, counts as plain integers.
  longint m_cnt [3][4];
  bit     m_ovf [3][4];
  int     m_nch [3] = '{4, 3, 3};
  longint m_max [3] = '{65535, 15, 15};
  bit     m_sat [3] = '{1'b0, 1'b0, 1'b1};

  function automatic void model_add(int d, int ch, int n);
    longint total;
    total = m_cnt[d][ch] + n;
    if (total > m_max[d]) m_ovf[d][ch] = 1'b1;
    if (m_sat[d]) m_cnt[d][ch] = (total > m_max[d]) ? m_max[d] : total;
    else          m_cnt[d][ch] = total % (m_max[d] + 1);
  endfunction

  function automatic logic [31:0] model_read(int d, int s);
    if (s < m_nch[d]) return 32'(m_cnt[d][s]);
    return 32'd0;
  endfunction

  function automatic logic [31:0] model_ovf(int d);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < m_nch[d]; i++) v[i] = m_ovf[d][i];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [3:0] m, input int hi, input int lo);
    lines = m;
    step(hi);
    lines = 4'b0000;
    step(lo);
  endtask

  task automatic pulses(input logic [3:0] m, input int n);
    repeat (n) pulse(m, 3, 3);
  endtask

  task automatic do_capture(input string tag);
    capture = 1'b1;
    step(1);
    capture = 1'b0;
    chk({tag, "_done_hi"}, {done_a, done_w, done_s}, 3'b111);
    step(1);
    chk({tag, "_done_lo"}, {done_a, done_w, done_s}, 3'b000);
  endtask

  task automatic check_counts(input string tag, input logic [15:0] ea,
                              input logic [3:0] ew, input logic [3:0] es);
    chk({tag, "_cnt_a"}, counted_a, ea);
    chk({tag, "_cnt_w"}, counted_w, ew);
    chk({tag, "_cnt_s"}, counted_s, es);
  endtask

  task automatic check_zero(input string tag);
    check_counts(tag, 16'd0, 4'd0, 4'd0);
    chk({tag, "_ovf"}, {ovf_a, ovf_w, ovf_s}, 10'd0);
    chk({tag, "_done"}, {done_a, done_w, done_s}, 3'b000);
`ifdef LINE_COUNTER_LIMIT_IRQ_EN
    chk({tag, "_irq"}, {irq_a, irq_w, irq_s}, 10'd0);
`endif
  endtask

  initial begin
    vecs[0]  = '{4'b0100,  5, 1'b1, 4'b0000, 2'd2, 16'd5,  4'd5,  4'd5,  4'b0, 3'b000, 3'b000};
    vecs[1]  = '{4'b0000,  0, 1'b1, 4'b0000, 2'd0, 16'd0,  4'd0,  4'd0,  4'b0, 3'b000, 3'b000};
    vecs[2]  = '{4'b0000,  0, 1'b1, 4'b0000, 2'd1, 16'd0,  4'd0,  4'd0,  4'b0, 3'b000, 3'b000};
    vecs[3]  = '{4'b0001, 17, 1'b1, 4'b0000, 2'd0, 16'd17, 4'd1,  4'd15, 4'b0, 3'b001, 3'b001};
    vecs[4]  = '{4'b0000,  0, 1'b1, 4'b0001, 2'd0, 16'd0,  4'd0,  4'd0,  4'b0, 3'b000, 3'b000};
    vecs[5]  = '{4'b0010,  3, 1'b0, 4'b0000, 2'd1, 16'd0,  4'd0,  4'd0,  4'b0, 3'b000, 3'b000};
    vecs[6]  = '{4'b0010,  2, 1'b1, 4'b0000, 2'd1, 16'd2,  4'd2,  4'd2,  4'b0, 3'b000, 3'b000};
    vecs[7]  = '{4'b1000,  4, 1'b1, 4'b0000, 2'd3, 16'd4,  4'd0,  4'd0,  4'b0, 3'b000, 3'b000};
    vecs[8]  = '{4'b0111, 20, 1'b1, 4'b0000, 2'd2, 16'd25, 4'd9,  4'd15, 4'b0, 3'b111, 3'b111};
    vecs[9]  = '{4'b0000,  0, 1'b1, 4'b0110, 2'd2, 16'd0,  4'd0,  4'd0,  4'b0, 3'b001, 3'b001};
    vecs[10] = '{4'b0000,  0, 1'b1, 4'b0000, 2'd0, 16'd20, 4'd4,  4'd15, 4'b0, 3'b001, 3'b001};
    vecs[11] = '{4'b0000,  0, 1'b1, 4'b0000, 2'd3, 16'd4,  4'd0,  4'd0,  4'b0, 3'b001, 3'b001};

    rst_n = 1'b0; lines = '0; enable = 1'b1; clear = '0; capture = 1'b0; sel = '0;
`ifdef LINE_COUNTER_LIMIT_IRQ_EN
    limit_a = '0; limit_small = '0;
`endif

    // Lines toggling under reset must leave everything at zero.
    for (int k = 0; k < 6; k++) begin
      lines = 4'($urandom_range(0, 15));
      step(2);
    end
    check_zero("reset");
    lines = 4'b0000;
    step(2);
    rst_n = 1'b1;
    step(6);
    check_zero("post_reset");

    for (int v = 0; v < 12; v++) begin
      enable = vecs[v].en;
      pulses(vecs[v].mask, vecs[v].n);
      step(6);
      if (vecs[v].clr != 4'b0000) begin
        clear = vecs[v].clr;
        step(1);
        clear = 4'b0000;
      end
      sel = vecs[v].sel;
      do_capture($sformatf("vec%0d", v));
      check_counts($sformatf("vec%0d", v), vecs[v].exp_a, vecs[v].exp_w, vecs[v].exp_s);
      chk($sformatf("vec%0d_ovf_a", v), ovf_a, vecs[v].eovf_a);
      chk($sformatf("vec%0d_ovf_w", v), ovf_w, vecs[v].eovf_w);
      chk($sformatf("vec%0d_ovf_s", v), ovf_s, vecs[v].eovf_s);
    end

    // Clear leaves snapshots alone; only the next capture shows the cleared counters.
    sel = 2'd0;
    step(1);
    chk("snap_keep_pre", counted_a, 32'd20);
    clear = 4'hF;
    step(1);
    clear = 4'h0;
    step(2);
    check_counts("snap_keep", 16'd20, 4'd4, 4'd15);
    chk("clear_ovf", {ovf_a, ovf_w, ovf_s}, 10'd0);
    do_capture("clear_all");
    check_counts("clear_all", 16'd0, 4'd0, 4'd0);

    // Rise while disabled, enable while high: nothing counted until a fresh pulse.
    enable = 1'b0;
    lines = 4'b0010;
    step(8);
    enable = 1'b1;
    step(8);
    lines = 4'b0000;
    step(6);
    sel = 2'd1;
    do_capture("en_hold");
    check_counts("en_hold", 16'd0, 4'd0, 4'd0);
    pulse(4'b0010, 3, 3);
    step(6);
    do_capture("en_pulse");
    check_counts("en_pulse", 16'd1, 4'd1, 4'd1);

    // Clear on the exact cycle the ch3 edge lands: the edge is lost.
    pulses(4'b1000, 7);
    step(6);
    sel = 2'd3;
    do_capture("ch3_seven");
    check_counts("ch3_seven", 16'd7, 4'd0, 4'd0);
    lines = 4'b1000;
    step(3);
    clear = 4'b1000;
    step(1);
    clear = 4'b0000;
    step(1);
    lines = 4'b0000;
    step(6);
    do_capture("clr_edge");
    check_counts("clr_edge", 16'd0, 4'd0, 4'd0);

    // Capture on the cycle the 10th ch2 edge lands; read-back in the same cycle shows the old snapshot.
    pulses(4'b0100, 9);
    step(6);
    lines = 4'b0100;
    step(3);
    sel = 2'd2;
    capture = 1'b1;
    step(1);
    capture = 1'b0;
    chk("cap_edge_done", {done_a, done_w, done_s}, 3'b111);
    check_counts("cap_edge_old", 16'd0, 4'd0, 4'd0);
    step(1);
    check_counts("cap_edge_new", 16'd9, 4'd9, 4'd9);
    lines = 4'b0000;
    step(6);
    do_capture("cap_edge_after");
    check_counts("cap_edge_after", 16'd10, 4'd10, 4'd10);

`ifdef LINE_COUNTER_LIMIT_IRQ_EN
    begin
      int irq_cycles;
      int irq_at;
      logic [15:0] lim_tab [2];
      int          exp_cyc [2];
      lim_tab = '{16'd3, 16'd0};
      exp_cyc = '{1, 0};
      for (int t = 0; t < 2; t++) begin
        clear = 4'b0010;
        step(1);
        clear = 4'b0000;
        limit_a = lim_tab[t];
        irq_cycles = 0;
        irq_at = 0;
        for (int k = 1; k <= 4; k++) begin
          lines = 4'b0010;
          for (int c = 0; c < 6; c++) begin
            if (c == 3) lines = 4'b0000;
            step(1);
            if (irq_a[1]) begin
              irq_cycles++;
              irq_at = k;
            end
          end
        end
        step(6);
        chk($sformatf("irq_cycles_lim%0d", lim_tab[t]), 32'(irq_cycles), 32'(exp_cyc[t]));
        chk($sformatf("irq_at_lim%0d", lim_tab[t]), 32'(irq_at), (t == 0) ? 32'd3 : 32'd0);
        chk($sformatf("irq_other_lim%0d", lim_tab[t]), {irq_a[3:2], irq_a[0], irq_w, irq_s}, 9'd0);
      end
      limit_a = '0;
    end
`endif

    // Asynchronous reset mid pulse-train, then release with ch0 already high.
    sel = 2'd2;
    step(1);
    chk("pre_rst_cnt", counted_a, 32'd10);
    lines = 4'b0100;
    step(1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    lines = 4'b0001;
    step(3);
    check_zero("in_rst");
    rst_n = 1'b1;
    step(10);
    lines = 4'b0000;
    step(4);
    pulse(4'b0001, 3, 3);
    step(6);
    sel = 2'd0;
    do_capture("rst_high");
    check_counts("rst_high", 16'd1, 4'd1, 4'd1);
    sel = 2'd2;
    step(1);
    check_counts("rst_lost", 16'd0, 4'd0, 4'd0);

    // Randomised rounds against the integer model.
    clear = 4'hF;
    step(1);
    clear = 4'h0;
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < 4; c++) begin
        m_cnt[d][c] = 0;
        m_ovf[d][c] = 1'b0;
      end

    for (int r = 0; r < 15; r++) begin
      int nadd [4];
      int nslots;
      logic [3:0] m;
      logic [3:0] clr;
      nadd = '{0, 0, 0, 0};
      enable = ($urandom_range(0, 4) != 0);
      nslots = $urandom_range(0, 12);
      for (int s = 0; s < nslots; s++) begin
        m = 4'($urandom_range(0, 15));
        pulse(m, $urandom_range(2, 4), $urandom_range(2, 4));
        if (enable)
          for (int c = 0; c < 4; c++) if (m[c]) nadd[c]++;
      end
      step(6);
      for (int d = 0; d < 3; d++)
        for (int c = 0; c < m_nch[d]; c++) model_add(d, c, nadd[c]);
      clr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      if (clr != 4'b0000) begin
        clear = clr;
        step(1);
        clear = 4'b0000;
        for (int d = 0; d < 3; d++)
          for (int c = 0; c < 4; c++)
            if (clr[c]) begin
              m_cnt[d][c] = 0;
              m_ovf[d][c] = 1'b0;
            end
      end
      do_capture($sformatf("rnd%0d", r));
      for (int s = 0; s < 4; s++) begin
        for (int d = 0; d < 3; d++) exp_q.push_back(model_read(d, s));
        sel = 2'(s);
        step(1);
        chk($sformatf("rnd%0d_sel%0d_a", r, s), counted_a, exp_q.pop_front());
        chk($sformatf("rnd%0d_sel%0d_w", r, s), counted_w, exp_q.pop_front());
        chk($sformatf("rnd%0d_sel%0d_s", r, s), counted_s, exp_q.pop_front());
      end
      chk($sformatf("rnd%0d_ovf_a", r), ovf_a, model_ovf(0));
      chk($sformatf("rnd%0d_ovf_w", r), ovf_w, model_ovf(1));
      chk($sformatf("rnd%0d_ovf_s", r), ovf_s, model_ovf(2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
